// File: rtl/io_pkg.sv
// Shared types and constants for the CPU output capture path.
//   IO_DATA_W   : default width of a CPU output word
//   cap_state_t : capture FSM states (RUN -> DRAIN -> DONE)
package io_pkg;

  localparam int IO_DATA_W = 64;

  typedef enum logic [1:0] {
    CAP_RUN,
    CAP_DRAIN,
    CAP_DONE
  } cap_state_t;

endpackage : io_pkg

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   push, wr_data   : write request and word
//   pop             : read request (ignored when empty)
//   rd_data         : head word, forced to 0 while empty
//   count           : words stored, 0..DEPTH
//   count_next      : value count will take at the next edge
//   full, empty     : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_en, rd_en;

  assign full       = (count_q == FULL_COUNT);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign count_next = count_d;
  assign rd_data    = empty ? '0 : mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO can still take a word.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_en    = pop & ~empty;
    wr_en    = push & (~full | rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (rd_en && !wr_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule : sync_fifo

// File: rtl/cpu_out_capture.sv
// Host-side receiver for the CPU output port. Every cycle out_signal is high
// one word is captured into a FIFO and offered to the host on a valid/ready
// stream. After halt the FSM stops capturing and raises done once drained.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   out_signal, out_data  : CPU output strobe and word
//   halt                  : CPU halt level
//   host_valid/host_data  : head word (data is 0 when not valid)
//   host_ready            : host accepts head word
//   count                 : words stored
//   overflow              : sticky, a CPU word was dropped
//   done                  : halt seen and FIFO drained
// Optional build macro OUT_CAPTURE_STATS_EN adds saturating counters
//   words_total (accepted pushes) and words_dropped (dropped pushes).
module cpu_out_capture
  import io_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   out_signal,
  input  logic [DATA_W-1:0]      out_data,
  input  logic                   halt,
  output logic                   host_valid,
  output logic [DATA_W-1:0]      host_data,
  input  logic                   host_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
`ifdef OUT_CAPTURE_STATS_EN
  output logic [31:0]            words_total,
  output logic [31:0]            words_dropped,
`endif
  output logic                   done
);

  localparam int ADDR_W = $clog2(DEPTH);

  cap_state_t      state_q, state_d;
  logic            overflow_q, overflow_d;
  logic            push, pop, drop;
  logic            fifo_full, fifo_empty;
  logic [ADDR_W:0] count_next;

  assign push       = out_signal && (state_q == CAP_RUN);
  assign pop        = host_valid && host_ready;
  assign drop       = push && fifo_full && !pop;
  assign host_valid = !fifo_empty;
  assign overflow   = overflow_q;
  assign done       = (state_q == CAP_DONE);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .wr_data    (out_data),
    .rd_data    (host_data),
    .count      (count),
    .count_next (count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // DRAIN looks at the post-edge count so done rises right after the last pop,
  // yet always spends at least one cycle in DRAIN.
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q | drop;
    case (state_q)
      CAP_RUN:   if (halt) state_d = CAP_DRAIN;
      CAP_DRAIN: if (count_next == '0) state_d = CAP_DONE;
      CAP_DONE:  state_d = CAP_DONE;
      default:   state_d = CAP_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CAP_RUN;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef OUT_CAPTURE_STATS_EN
  logic [31:0] words_total_q, words_total_d;
  logic [31:0] words_dropped_q, words_dropped_d;

  assign words_total   = words_total_q;
  assign words_dropped = words_dropped_q;

  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    words_total_d   = words_total_q;
    words_dropped_d = words_dropped_q;
    if (push && !drop && (words_total_q != '1))  words_total_d   = words_total_q + 1'b1;
    if (drop && (words_dropped_q != '1))         words_dropped_d = words_dropped_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_total_q   <= '0;
      words_dropped_q <= '0;
    end else begin
      words_total_q   <= words_total_d;
      words_dropped_q <= words_dropped_d;
    end
  end
`endif

endmodule : cpu_out_capture

// File: tb/tb_cpu_out_capture.sv
// Scoreboard bench for cpu_out_capture: accepted words are queued when
// driven, and a negedge monitor checks each word the host pops.
module tb_cpu_out_capture;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              out_signal = 1'b0;
  logic [DATA_W-1:0] out_data = '0;
  logic              halt = 1'b0;
  logic              host_valid;
  logic [DATA_W-1:0] host_data;
  logic              host_ready = 1'b0;
  logic [3:0]        count;
  logic              overflow;
  logic              done;
`ifdef OUT_CAPTURE_STATS_EN
  logic [31:0]       words_total;
  logic [31:0]       words_dropped;
`endif

  int nChecks = 0;
  int nFails  = 0;
  logic [DATA_W-1:0] expQ [$];

  always #5 clk = ~clk;

  cpu_out_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .out_signal    (out_signal),
    .out_data      (out_data),
    .halt          (halt),
    .host_valid    (host_valid),
    .host_data     (host_data),
    .host_ready    (host_ready),
    .count         (count),
    .overflow      (overflow),
`ifdef OUT_CAPTURE_STATS_EN
    .words_total   (words_total),
    .words_dropped (words_dropped),
`endif
    .done          (done)
  );

  // Compare one value and report it
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, wait for the edge, return 1ns after it
  task automatic applyStimulus(input logic os, input logic [63:0] od, input logic h, input logic hr);
    out_signal = os;
    out_data   = od;
    halt       = h;
    host_ready = hr;
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [63:0] w, input bit expectAccepted);
    if (expectAccepted) expQ.push_back(w);
    applyStimulus(1'b1, w, 1'b0, 1'b0);
  endtask

  task automatic idleCycles(input int n, input logic hr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, hr);
  endtask

  task automatic pulseReset();
    out_signal = 1'b0;
    host_ready = 1'b0;
    halt       = 1'b0;
    reset      = 1'b0;
    expQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: a handshake at the next edge is visible at the negedge before it
  always @(negedge clk) begin
    if (reset && host_valid && host_ready) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL pop_unexpected: got %0h expected no word at %0t", host_data, $time);
      end else begin
        checkOutput("pop_data", host_data, expQ.pop_front());
      end
    end else if (reset && !host_valid) begin
      checkOutput("idle_data_zero", host_data, 64'h0);
    end
  end

  initial begin
    // Reset state
    #3;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_valid", 64'(host_valid), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single word
    pushWord(64'h5, 1'b1);
    checkOutput("single_valid", 64'(host_valid), 64'd1);
    checkOutput("single_data", host_data, 64'h5);
    checkOutput("single_count", 64'(count), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("single_count_after_pop", 64'(count), 64'd0);
    checkOutput("single_valid_after_pop", 64'(host_valid), 64'd0);

    // Fill and overflow
    for (int i = 1; i <= 9; i++) pushWord(64'(i), i <= DEPTH);
    checkOutput("fill_count", 64'(count), 64'd8);
    checkOutput("fill_overflow", 64'(overflow), 64'd1);
    idleCycles(DEPTH, 1'b1);
    checkOutput("fill_drained_count", 64'(count), 64'd0);
    checkOutput("fill_queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("overflow_sticky", 64'(overflow), 64'd1);

    // Full plus simultaneous push/pop
    pulseReset();
    checkOutput("reset_clears_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < DEPTH; i++) pushWord(64'(16 + i), 1'b1);
    expQ.push_back(64'hAA);
    applyStimulus(1'b1, 64'hAA, 1'b0, 1'b1);
    checkOutput("full_simul_count", 64'(count), 64'd8);
    checkOutput("full_simul_overflow", 64'(overflow), 64'd0);
    idleCycles(DEPTH, 1'b1);
    checkOutput("full_simul_queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("full_simul_count_end", 64'(count), 64'd0);

    // Halt drain
    pulseReset();
    for (int i = 1; i <= 3; i++) pushWord(64'(i), 1'b1);
    expQ.push_back(64'h4);
    applyStimulus(1'b1, 64'h4, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'h5, 1'b0, 1'b0);
    checkOutput("halt_count", 64'(count), 64'd4);
    checkOutput("halt_done_early", 64'(done), 64'd0);
    idleCycles(3, 1'b1);
    checkOutput("halt_count_one_left", 64'(count), 64'd1);
    checkOutput("halt_done_one_left", 64'(done), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("halt_done_after_last_pop", 64'(done), 64'd1);
    checkOutput("halt_queue_empty", 64'(expQ.size()), 64'd0);

    // Halt when empty
    pulseReset();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("empty_halt_drain_cycle", 64'(done), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("empty_halt_done", 64'(done), 64'd1);
    applyStimulus(1'b1, 64'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h78, 1'b0, 1'b0);
    checkOutput("done_ignores_out_count", 64'(count), 64'd0);
    checkOutput("done_ignores_out_valid", 64'(host_valid), 64'd0);
    checkOutput("done_stays", 64'(done), 64'd1);

    // Asynchronous reset between edges
    pulseReset();
    for (int i = 1; i <= 9; i++) pushWord(64'(32 + i), i <= DEPTH);
    idleCycles(3, 1'b1);
    out_signal = 1'b0;
    host_ready = 1'b0;
    checkOutput("pre_async_count", 64'(count), 64'd5);
    checkOutput("pre_async_overflow", 64'(overflow), 64'd1);
    #2;
    reset = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async_count", 64'(count), 64'd0);
    checkOutput("async_overflow", 64'(overflow), 64'd0);
    checkOutput("async_valid", 64'(host_valid), 64'd0);
    checkOutput("async_done", 64'(done), 64'd0);
`ifdef OUT_CAPTURE_STATS_EN
    checkOutput("async_words_total", 64'(words_total), 64'd0);
    checkOutput("async_words_dropped", 64'(words_dropped), 64'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    idleCycles(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_cpu_out_capture

// File: doc/cpu_out_capture.md
Name: cpu_out_capture

Overview:
- Host-side receiver for the CPU output port: captures every word the CPU presents on out_signal/out_data into a small FIFO and hands the words to the host through a valid/ready stream.
- Tracks the CPU halt so the host knows when all output has been drained.
- Sits between cpu and the bench or host logic, replacing per-timestep polling of out_signal.

Parameters:
- DATA_W, 64, width of out_data and host_data.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- out_signal  in  1  CPU output strobe; each clk cycle it is high is one word
- out_data  in  DATA_W  CPU output word, valid when out_signal=1
- halt  in  1  CPU halt level
- host_valid  out  1  FIFO head word available
- host_data  out  DATA_W  FIFO head word; 0 when host_valid=0
- host_ready  in  1  host accepts head word this cycle
- count  out  ADDR_W+1  words currently stored, 0..DEPTH
- overflow  out  1  sticky; a CPU word was dropped
- done  out  1  halt seen and FIFO fully drained

Behaviour:
- Reset (reset=0, asynchronous): pointers=0, count=0, overflow=0, state=RUN, host_valid=0, host_data=0, done=0. FIFO storage is not cleared. Reset mid-operation discards all stored words.
- push = out_signal and state==RUN. pop = host_valid and host_ready.
- Latency: a word pushed at edge N gives host_valid=1 after edge N. Show-ahead: host_data = mem[rd_ptr] combinationally while count>0.
- Push when count<DEPTH: store at wr_ptr, wr_ptr+1 (wraps mod DEPTH), count+1.
- Pop: rd_ptr+1 (wraps), count-1.
- Simultaneous push and pop: both occur, count unchanged. This also applies when full, so no drop.
- Push when full without pop: word dropped, overflow set to 1 and held until reset. count stays DEPTH.
- Pop when empty is impossible, because host_valid=0.
- State machine (cap_state_t):
  - RUN: capture enabled. If halt=1 at an edge, go to DRAIN. A push in that same cycle is still accepted.
  - DRAIN: out_signal ignored. When count==0 after the edge, go to DONE. This takes one cycle minimum even if already empty.
  - DONE: done=1. out_signal ignored. Host may not see further words. Stays until reset. halt deasserting has no effect.
- done is registered: it is 1 only in DONE.

Optional Feature:
- Macro: OUT_CAPTURE_STATS_EN.
- With the macro defined: extra outputs words_total [31:0] (accepted pushes) and words_dropped [31:0] (dropped pushes). Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Without the macro: those ports and counters do not exist. overflow is the only loss indication.

Decomposition:
- Package io_pkg holds:
  - localparam IO_DATA_W = 64
  - typedef enum logic [1:0] {CAP_RUN, CAP_DRAIN, CAP_DONE} cap_state_t
- One natural sub-module: sync_fifo (DATA_W, DEPTH). It has push/pop, count, full/empty, and show-ahead read.
- cpu_out_capture contains the FSM, the drop/overflow logic, and the optional stats.

Test Plan:
- Single word: after reset release, out_signal=1 for one cycle with out_data=64'h0000_0000_0000_0005, host_ready=0. Expect host_valid=1, host_data=5, count=1 on the next cycle. Then host_ready=1 for one cycle gives count=0 and host_valid=0.
- Fill and overflow: push 9 words 1..9 with host_ready=0, DEPTH=8. Expect count=8, overflow=1, and a drain returning exactly 1..8 in order.
- Full plus simultaneous: FIFO full, host_ready=1 and out_signal=1 with value 64'hAA in the same cycle. Expect count stays 8, overflow stays 0, and 64'hAA is the last word drained.
- Halt drain: push 3 words, then halt=1 with out_signal=1 (value 4) on the same edge, then out_signal=1 (value 5). Expect 4 stored and 5 ignored. done=0 until 4 words are popped, done=1 the cycle after the final pop.
- Halt when empty: halt=1 with count=0. Expect DRAIN for one cycle, then done=1. Later out_signal pulses leave count=0.
- Async reset: reset=0 between edges with count=5 and overflow=1. Expect count=0, overflow=0, host_valid=0, done=0 immediately, without waiting for clk. With OUT_CAPTURE_STATS_EN, words_total=0.
